// File: rtl/shapool_pkg.sv
// Shared definitions for the shapool search path: sequencer state
// encoding and default geometry shared by the pipeline and IO block.
package shapool_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } seq_state_t;

    localparam int NONCE_WIDTH_DEF     = 32;
    localparam int DEVICE_ID_WIDTH_DEF = 8;
    localparam int PIPE_LATENCY_DEF    = 128;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that stops at LIMIT; synchronous clear wins over enable.
module sat_counter #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CAP = WIDTH'(LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != CAP) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/nonce_sequencer.sv
// Issues {device_id, counter} nonces to the hash pipeline and reports
// the latency-corrected winning nonce, exhaustion or halt.
module nonce_sequencer
    import shapool_pkg::*;
#(
    parameter int NONCE_WIDTH     = NONCE_WIDTH_DEF,
    parameter int DEVICE_ID_WIDTH = DEVICE_ID_WIDTH_DEF,
    parameter int PIPE_LATENCY    = PIPE_LATENCY_DEF
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    start,
    input  logic                                    halt,
    input  logic [NONCE_WIDTH-DEVICE_ID_WIDTH-1:0]  nonce_start,
    input  logic [DEVICE_ID_WIDTH-1:0]              device_id,
    output logic [NONCE_WIDTH-1:0]                  nonce,
    output logic                                    nonce_valid,
    input  logic                                    hash_match,
    output logic [NONCE_WIDTH-1:0]                  result_nonce,
    output logic                                    success,
    output logic                                    exhausted,
    output logic                                    busy
);

    localparam int CW = NONCE_WIDTH - DEVICE_ID_WIDTH;
    localparam int FW = $clog2(PIPE_LATENCY + 1);

    localparam logic [FW-1:0] FILL_FULL  = FW'(PIPE_LATENCY);
    localparam logic [FW-1:0] DRAIN_LAST = FW'(PIPE_LATENCY - 1);
    localparam logic [CW-1:0] LAT_CW     = CW'(PIPE_LATENCY);
    localparam logic [CW:0]   ISSUE_LAST = {1'b0, {CW{1'b1}}};

    if (PIPE_LATENCY < 1 ||
        longint'(PIPE_LATENCY) > (longint'(1) << CW)) begin : g_bad_latency
        $error("nonce_sequencer: PIPE_LATENCY out of range");
    end

    seq_state_t state;
    seq_state_t state_next;

    logic [CW-1:0]              cnt;
    logic [DEVICE_ID_WIDTH-1:0] dev;
    logic [CW:0]                issued;
    logic [FW-1:0]              fill;
    logic [FW-1:0]              drain;

    logic load;
    logic hit;
    logic exhaust;
    logic in_run;
    logic in_drain;

    assign in_run   = (state == ST_RUN);
    assign in_drain = (state == ST_DRAIN);

    assign nonce       = {dev, cnt};
    assign nonce_valid = in_run;
    assign busy        = in_run | in_drain;

    sat_counter #(
        .WIDTH (FW),
        .LIMIT (PIPE_LATENCY)
    ) u_fill (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (load),
        .enable  (in_run),
        .count   (fill)
    );

    sat_counter #(
        .WIDTH (FW),
        .LIMIT (PIPE_LATENCY)
    ) u_drain (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (load),
        .enable  (in_drain),
        .count   (drain)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A match only counts once the pipeline holds a real nonce.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        hit        = 1'b0;
        exhaust    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (hash_match && fill == FILL_FULL) begin
                    hit        = 1'b1;
                    state_next = ST_DONE;
                end else if (halt) begin
                    state_next = ST_DONE;
                end else if (issued == ISSUE_LAST) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (hash_match) begin
                    hit        = 1'b1;
                    state_next = ST_DONE;
                end else if (halt) begin
                    state_next = ST_DONE;
                end else if (drain == DRAIN_LAST) begin
                    exhaust    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            dev          <= '0;
            issued       <= '0;
            success      <= 1'b0;
            exhausted    <= 1'b0;
            result_nonce <= '0;
        end else if (load) begin
            cnt          <= nonce_start;
            dev          <= device_id;
            issued       <= '0;
            success      <= 1'b0;
            exhausted    <= 1'b0;
            result_nonce <= '0;
        end else begin
            if (busy) begin
                cnt <= cnt + CW'(1);
            end
            if (in_run) begin
                issued <= issued + (CW+1)'(1);
            end
            // cnt has run PIPE_LATENCY ahead of the nonce that matched.
            if (hit) begin
                success      <= 1'b1;
                result_nonce <= {dev, cnt - LAT_CW};
            end
            if (exhaust) begin
                exhausted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nonce_sequencer.sv
// Randomised and directed bench for nonce_sequencer with a per-run
// outcome model computed from the search rules.
module tb_nonce_sequencer;

    localparam int NW   = 8;
    localparam int DW   = 2;
    localparam int PL   = 4;
    localparam int CW   = NW - DW;
    localparam int NN   = 1 << CW;
    localparam int LAST = NN + PL;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          halt = 1'b0;
    logic          hash_match = 1'b0;
    logic [CW-1:0] nonce_start = '0;
    logic [DW-1:0] device_id = '0;
    logic [NW-1:0] nonce;
    logic          nonce_valid;
    logic [NW-1:0] result_nonce;
    logic          success;
    logic          exhausted;
    logic          busy;

    nonce_sequencer #(
        .NONCE_WIDTH     (NW),
        .DEVICE_ID_WIDTH (DW),
        .PIPE_LATENCY    (PL)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .halt         (halt),
        .nonce_start  (nonce_start),
        .device_id    (device_id),
        .nonce        (nonce),
        .nonce_valid  (nonce_valid),
        .hash_match   (hash_match),
        .result_nonce (result_nonce),
        .success      (success),
        .exhausted    (exhausted),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    bit chk_en = 0;
    int j = 0;
    int s_m = 0;
    int d_m = 0;
    bit mv [1:LAST];
    bit hv [1:LAST];
    int e = LAST;
    bit win = 0;
    bit exh = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [NW-1:0] mk(int d, int c);
        return NW'((d << CW) | (c & (NN - 1)));
    endfunction

    // Cycle j of a run: j<=NN issues seed+j-1, then PL drain cycles.
    // A match at j>PL names the nonce issued PL cycles earlier.
    function automatic void decide();
        e   = LAST;
        win = 0;
        exh = 1;
        for (int k = 1; k <= LAST; k++) begin
            if (mv[k] && k > PL) begin
                e   = k;
                win = 1;
                exh = 0;
                break;
            end
            if (hv[k]) begin
                e   = k;
                exh = 0;
                break;
            end
        end
    endfunction

    function automatic void clear_vec();
        for (int k = 1; k <= LAST; k++) begin
            mv[k] = 0;
            hv[k] = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (j <= e) begin
                chk("busy_run", 32'(busy), 32'd1);
                chk("valid_run", 32'(nonce_valid), 32'(j <= NN));
                if (j <= NN) begin
                    chk("nonce", 32'(nonce), 32'(mk(d_m, s_m + j - 1)));
                end
                chk("success_run", 32'(success), 32'd0);
                chk("exhausted_run", 32'(exhausted), 32'd0);
                chk("result_run", 32'(result_nonce), 32'd0);
            end else begin
                chk("busy_done", 32'(busy), 32'd0);
                chk("valid_done", 32'(nonce_valid), 32'd0);
                chk("success_done", 32'(success), 32'(win));
                chk("exhausted_done", 32'(exhausted), 32'(exh));
                chk("result_done", 32'(result_nonce),
                    win ? 32'(mk(d_m, s_m + e - 1 - PL)) : 32'd0);
            end
        end
    end

    task automatic do_run(input int s, input int d, input int stop);
        @(posedge clk);
        chk_en = 0;
        s_m = s;
        d_m = d;
        decide();
        #1;
        start       = 1'b1;
        nonce_start = CW'(s);
        device_id   = DW'(d);
        hash_match  = 1'b0;
        halt        = 1'b0;
        @(posedge clk);
        #1;
        start      = 1'b0;
        j          = 1;
        hash_match = mv[1];
        halt       = hv[1];
        chk_en     = 1;
        while (j < ((stop > 0) ? stop : e + 3)) begin
            @(posedge clk);
            #1;
            j++;
            if (j <= e) begin
                hash_match  = mv[j];
                halt        = hv[j];
                start       = ($urandom % 16 == 0);
                nonce_start = CW'($urandom);
            end else begin
                hash_match = 1'($urandom);
                halt       = 1'($urandom);
                start      = 1'b0;
            end
        end
        start      = 1'b0;
        hash_match = 1'b0;
        halt       = 1'b0;
    endtask

    initial begin
        clear_vec();
        #12;
        chk("rst_nonce", 32'(nonce), 32'd0);
        chk("rst_valid", 32'(nonce_valid), 32'd0);
        chk("rst_success", 32'(success), 32'd0);
        chk("rst_exhausted", 32'(exhausted), 32'd0);
        chk("rst_result", 32'(result_nonce), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Async reset in the middle of a run.
        clear_vec();
        do_run(8'h2A, 3, 10);
        chk_en = 0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_nonce", 32'(nonce), 32'd0);
        chk("mid_rst_valid", 32'(nonce_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_success", 32'(success), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        clear_vec();
        mv[9] = 1;
        do_run(8'h10, 1, 0);
        chk("basic_success", 32'(success), 32'd1);
        chk("basic_result", 32'(result_nonce), 32'h54);
        chk("basic_busy", 32'(busy), 32'd0);

        clear_vec();
        for (int k = 1; k <= 5; k++) mv[k] = 1;
        do_run(8'h20, 2, 0);
        chk("fill_result", 32'(result_nonce), 32'hA0);

        clear_vec();
        do_run(8'h3E, 0, 0);
        chk("exh_flag", 32'(exhausted), 32'd1);
        chk("exh_success", 32'(success), 32'd0);
        chk("exh_len", 32'(e), 32'(LAST));

        clear_vec();
        mv[LAST] = 1;
        do_run(8'h3E, 0, 0);
        chk("lastdrain_success", 32'(success), 32'd1);
        chk("lastdrain_result", 32'(result_nonce), 32'h3D);

        clear_vec();
        mv[7] = 1;
        hv[7] = 1;
        do_run(8'h05, 1, 0);
        chk("halt_match_success", 32'(success), 32'd1);
        chk("halt_match_result", 32'(result_nonce), 32'h47);

        clear_vec();
        hv[10] = 1;
        do_run(8'h30, 2, 0);
        chk("halt_success", 32'(success), 32'd0);
        chk("halt_exhausted", 32'(exhausted), 32'd0);
        chk("halt_busy", 32'(busy), 32'd0);

        for (int r = 0; r < 12; r++) begin
            clear_vec();
            if (r % 4 != 3) begin
                for (int k = 1; k <= LAST; k++) begin
                    mv[k] = ($urandom % 40 == 0);
                    hv[k] = ($urandom % 70 == 0);
                end
            end
            do_run(int'($urandom % NN), int'($urandom % 4), 0);
        end

        @(posedge clk);
        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
